// File: rtl/accum_shift_unit_if.sv
// Handshake/data bundle between the accumulator control FSM and accum_shift_unit.
// The cout signal exists only when SHIFT_CARRY_EN is defined.
interface accum_shift_unit_if #(
  parameter int N  = 8,
  parameter int SW = 3
);
  logic          start;
  logic [2:0]    op;
  logic [SW-1:0] amt;
  logic          ser_in;
  logic [N-1:0]  d_in;
  logic [N-1:0]  q;
  logic          busy;
  logic          done;
`ifdef SHIFT_CARRY_EN
  logic          cout;

  modport master (output start, op, amt, ser_in, d_in, input q, busy, done, cout);
  modport slave  (input start, op, amt, ser_in, d_in, output q, busy, done, cout);
`else
  modport master (output start, op, amt, ser_in, d_in, input q, busy, done);
  modport slave  (input start, op, amt, ser_in, d_in, output q, busy, done);
`endif
endinterface

// File: rtl/accum_shift_unit.sv
// Iterative accumulator shift/rotate unit: parallel load or 1-bit-per-clock shift/rotate
// behind a start/busy/done handshake. Optional carry-out flop under SHIFT_CARRY_EN.
module accum_shift_unit #(
  parameter int N  = 8,
  parameter int SW = 3
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               set,
  accum_shift_unit_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;

  state_t        r_state;
  logic [N-1:0]  r_q;
  logic [2:0]    r_op;
  logic [SW-1:0] r_count;
  logic [N-1:0]  w_step_q;

  // One 1-bit step of the latched operation; ser_in is live, not captured at accept.
  always_comb begin
    // NOTE: default first so no path leaves w_step_q unassigned and infers a latch.
    w_step_q = r_q;
    case (r_op)
      OP_SHL:  w_step_q = {r_q[N-2:0], bus.ser_in};
      OP_SHR:  w_step_q = {bus.ser_in, r_q[N-1:1]};
      OP_ROL:  w_step_q = {r_q[N-2:0], r_q[N-1]};
      OP_ROR:  w_step_q = {r_q[0], r_q[N-1:1]};
      OP_ASR:  w_step_q = {r_q[N-1], r_q[N-1:1]};
      default: w_step_q = r_q;
    endcase
  end

`ifdef SHIFT_CARRY_EN
  logic r_cout;
  logic w_step_out;

  always_comb begin
    w_step_out = 1'b0;
    case (r_op)
      OP_SHL, OP_ROL:         w_step_out = r_q[N-1];
      OP_SHR, OP_ROR, OP_ASR: w_step_out = r_q[0];
      default:                w_step_out = 1'b0;
    endcase
  end

  assign bus.cout = r_cout;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_op    <= '0;
      r_count <= '0;
`ifdef SHIFT_CARRY_EN
      r_cout  <= 1'b0;
`endif
    end else if (!set) begin
      // Preset aborts whatever is in flight without a done pulse.
      r_state <= ST_IDLE;
      r_q     <= '1;
      r_count <= '0;
`ifdef SHIFT_CARRY_EN
      r_cout  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_op    <= bus.op;
            r_count <= bus.amt;
            case (bus.op)
              OP_LOAD: begin
                r_q     <= bus.d_in;
`ifdef SHIFT_CARRY_EN
                r_cout  <= 1'b0;
`endif
                r_state <= ST_DONE;
              end
              OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR:
                r_state <= (bus.amt == '0) ? ST_DONE : ST_SHIFT;
              default:
                r_state <= ST_DONE;
            endcase
          end
        end
        ST_SHIFT: begin
          r_q     <= w_step_q;
`ifdef SHIFT_CARRY_EN
          r_cout  <= w_step_out;
`endif
          r_count <= r_count - 1'b1;
          if (r_count == SW'(1))
            r_state <= ST_DONE;
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.q    = r_q;
  assign bus.busy = (r_state != ST_IDLE);
  assign bus.done = (r_state == ST_DONE);

endmodule

// File: tb/tb_accum_shift_unit.sv
// Directed bench for accum_shift_unit (N=8, SW=3); carry checks enabled with SHIFT_CARRY_EN.
module tb_accum_shift_unit;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic set = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  accum_shift_unit_if #(.N(8), .SW(3)) bus ();

  accum_shift_unit #(.N(8), .SW(3)) dut (
    .clk (clk),
    .clr (clr),
    .set (set),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one op, wait (bounded) for done, then step back into IDLE.
  // ticks = edges after the accept edge until done is seen.
  task automatic run_op(input string name, input logic [2:0] op, input logic [2:0] amt,
                        input logic [7:0] d, input logic si, output int ticks);
    bus.start = 1'b1; bus.op = op; bus.amt = amt; bus.d_in = d; bus.ser_in = si;
    tick();
    bus.start = 1'b0;
    ticks = 0;
    while (bus.done !== 1'b1 && ticks < 40) begin
      tick();
      ticks++;
    end
    if (bus.done !== 1'b1) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: done=%b after 40 cycles, required 1", name, bus.done);
      ticks = -1;
    end
    tick();
  endtask

  task automatic test_reset();
    clr = 1'b0; set = 1'b1;
    bus.start = 1'b0; bus.op = OP_NOP; bus.amt = '0; bus.d_in = '0; bus.ser_in = 1'b0;
    tick(); tick();
    n_cmp++;
    if (bus.q !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: q=%h busy=%b done=%b, required 00/0/0", bus.q, bus.busy, bus.done);
    end
    clr = 1'b1;
    tick();
  endtask

  task automatic test_load();
    int t;
    bus.start = 1'b1; bus.op = OP_LOAD; bus.d_in = 8'hA5; bus.amt = 3'd0;
    tick();
    bus.start = 1'b0;
    n_cmp++;
    if (bus.q !== 8'hA5 || bus.done !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL load_accept: q=%h done=%b busy=%b, required a5/1/1", bus.q, bus.done, bus.busy);
    end
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.q !== 8'hA5) begin
      n_fail++;
      $display("FAIL load_after: q=%h done=%b busy=%b, required a5/0/0", bus.q, bus.done, bus.busy);
    end
    run_op("nop", OP_NOP, 3'd5, 8'h00, 1'b1, t);
    n_cmp++;
    if (t !== 0 || bus.q !== 8'hA5) begin
      n_fail++;
      $display("FAIL nop: ticks=%0d q=%h, required 0/a5", t, bus.q);
    end
  endtask

  task automatic test_shifts();
    int t;
    run_op("ld81", OP_LOAD, 3'd0, 8'h81, 1'b0, t);
    run_op("shl3", OP_SHL, 3'd3, 8'h00, 1'b1, t);
    n_cmp++;
    if (bus.q !== 8'h0F || t !== 3) begin
      n_fail++;
      $display("FAIL shl3: q=%h ticks=%0d, required 0f/3", bus.q, t);
    end
`ifdef SHIFT_CARRY_EN
    n_cmp++;
    if (bus.cout !== 1'b0) begin
      n_fail++;
      $display("FAIL shl3_cout: cout=%b, required 0", bus.cout);
    end
`endif
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL shl3_idle: busy=%b done=%b, required 0/0", bus.busy, bus.done);
    end
    run_op("ld81b", OP_LOAD, 3'd0, 8'h81, 1'b0, t);
    run_op("ror7", OP_ROR, 3'd7, 8'h00, 1'b0, t);
    n_cmp++;
    if (bus.q !== 8'h03 || t !== 7) begin
      n_fail++;
      $display("FAIL ror7: q=%h ticks=%0d, required 03/7", bus.q, t);
    end
    run_op("ld90", OP_LOAD, 3'd0, 8'h90, 1'b0, t);
    run_op("asr7", OP_ASR, 3'd7, 8'h00, 1'b0, t);
    n_cmp++;
    if (bus.q !== 8'hFF) begin
      n_fail++;
      $display("FAIL asr7: q=%h, required ff", bus.q);
    end
    run_op("shr0", OP_SHR, 3'd0, 8'h00, 1'b0, t);
    n_cmp++;
    if (bus.q !== 8'hFF || t !== 0) begin
      n_fail++;
      $display("FAIL shr0: q=%h ticks=%0d, required ff/0", bus.q, t);
    end
    run_op("ldf0", OP_LOAD, 3'd0, 8'hF0, 1'b0, t);
    run_op("shr2", OP_SHR, 3'd2, 8'h00, 1'b0, t);
    n_cmp++;
    if (bus.q !== 8'h3C) begin
      n_fail++;
      $display("FAIL shr2: q=%h, required 3c", bus.q);
    end
    run_op("ld96", OP_LOAD, 3'd0, 8'h96, 1'b0, t);
    run_op("asr2", OP_ASR, 3'd2, 8'h00, 1'b0, t);
    n_cmp++;
    if (bus.q !== 8'hE5) begin
      n_fail++;
      $display("FAIL asr2: q=%h, required e5", bus.q);
    end
  endtask

  task automatic test_back_to_back();
    int t;
    run_op("ld81c", OP_LOAD, 3'd0, 8'h81, 1'b0, t);
    run_op("rol1", OP_ROL, 3'd1, 8'h00, 1'b0, t);
    n_cmp++;
    if (bus.q !== 8'h03) begin
      n_fail++;
      $display("FAIL rol1: q=%h, required 03", bus.q);
    end
    run_op("rol2", OP_ROL, 3'd2, 8'h00, 1'b0, t);
    n_cmp++;
    if (bus.q !== 8'h0C || t !== 2) begin
      n_fail++;
      $display("FAIL rol2: q=%h ticks=%0d, required 0c/2", bus.q, t);
    end
  endtask

  task automatic test_start_while_busy();
    int t;
    run_op("ld01", OP_LOAD, 3'd0, 8'h01, 1'b0, t);
    bus.start = 1'b1; bus.op = OP_SHL; bus.amt = 3'd5; bus.ser_in = 1'b0; bus.d_in = 8'hEE;
    tick();
    bus.op = OP_LOAD; bus.amt = 3'd1;
    t = 0;
    while (bus.done !== 1'b1 && t < 40) begin
      tick();
      t++;
    end
    n_cmp++;
    if (bus.q !== 8'h20 || t !== 5) begin
      n_fail++;
      $display("FAIL busy_ignore: q=%h ticks=%0d, required 20/5", bus.q, t);
    end
    tick();
    n_cmp++;
    if (bus.q !== 8'h20 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_ignore: q=%h busy=%b, required 20/0", bus.q, bus.busy);
    end
    tick();
    bus.start = 1'b0;
    n_cmp++;
    if (bus.q !== 8'hEE || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_accept: q=%h done=%b, required ee/1", bus.q, bus.done);
    end
    tick();
  endtask

  task automatic test_clr_mid_shift();
    bus.start = 1'b1; bus.op = OP_SHL; bus.amt = 3'd5; bus.ser_in = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    clr = 1'b0;
    tick();
    clr = 1'b1;
    n_cmp++;
    if (bus.q !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_mid: q=%h busy=%b done=%b, required 00/0/0", bus.q, bus.busy, bus.done);
    end
    tick(); tick();
    n_cmp++;
    if (bus.done !== 1'b0 || bus.q !== 8'h00) begin
      n_fail++;
      $display("FAIL clr_nodone: q=%h done=%b, required 00/0", bus.q, bus.done);
    end
  endtask

  task automatic test_set();
    bus.start = 1'b1; bus.op = OP_ROL; bus.amt = 3'd6; bus.ser_in = 1'b0;
    tick();
    bus.start = 1'b0;
    tick();
    set = 1'b0;
    tick();
    set = 1'b1;
    n_cmp++;
    if (bus.q !== 8'hFF || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL set_abort: q=%h busy=%b, required ff/0", bus.q, bus.busy);
    end
    clr = 1'b0;
    tick();
    clr = 1'b1;
    set = 1'b0; bus.start = 1'b1; bus.op = OP_LOAD; bus.d_in = 8'h12;
    tick();
    set = 1'b1; bus.start = 1'b0;
    n_cmp++;
    if (bus.q !== 8'hFF || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL set_start: q=%h busy=%b done=%b, required ff/0/0", bus.q, bus.busy, bus.done);
    end
    tick();
    n_cmp++;
    if (bus.done !== 1'b0 || bus.q !== 8'hFF) begin
      n_fail++;
      $display("FAIL set_nodone: q=%h done=%b, required ff/0", bus.q, bus.done);
    end
    clr = 1'b0; set = 1'b0;
    tick();
    clr = 1'b1; set = 1'b1;
    n_cmp++;
    if (bus.q !== 8'h00) begin
      n_fail++;
      $display("FAIL clr_over_set: q=%h, required 00", bus.q);
    end
  endtask

`ifdef SHIFT_CARRY_EN
  task automatic test_carry();
    int t;
    run_op("ld80", OP_LOAD, 3'd0, 8'h80, 1'b0, t);
    run_op("shl1", OP_SHL, 3'd1, 8'h00, 1'b0, t);
    n_cmp++;
    if (bus.cout !== 1'b1 || bus.q !== 8'h00) begin
      n_fail++;
      $display("FAIL carry_shl: cout=%b q=%h, required 1/00", bus.cout, bus.q);
    end
    run_op("ld00", OP_LOAD, 3'd0, 8'h00, 1'b0, t);
    n_cmp++;
    if (bus.cout !== 1'b0) begin
      n_fail++;
      $display("FAIL carry_load: cout=%b, required 0", bus.cout);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_shifts();
    test_back_to_back();
    test_start_while_busy();
    test_clr_mid_shift();
    test_set();
`ifdef SHIFT_CARRY_EN
    test_carry();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
